// File: rtl/fec.sv
// 2-D even-parity FEC checker/corrector: two-stage pipeline, one DEPTH x WIDTH matrix per clock.
// Optional FEC_ERR_COUNT_EN adds a saturating count of corrected matrices (err_count).
module fec #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTH-1:0][WIDTH-1:0]  data_in,
  input  logic [DEPTH-1:0]             row_parity,
  input  logic [WIDTH-1:0]             col_parity,
  output logic [DEPTH-1:0][WIDTH-1:0]  data_corrected,
  output logic                         error_detected,
  output logic                         error_corrected,
`ifdef FEC_ERR_COUNT_EN
  output logic [15:0]                  err_count,
`endif
  output logic                         complete
);

  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic int ones_row(input logic [DEPTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int ones_col(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DEPTH-1:0]            row_syn_p0;
  logic [WIDTH-1:0]            col_syn_p0;

  logic [DEPTH-1:0][WIDTH-1:0] data_p1;
  logic [DEPTH-1:0]            row_syn_p1;
  logic [WIDTH-1:0]            col_syn_p1;
  logic                        vld_p1;

  int                          row_cnt;
  int                          col_cnt;
  logic                        single_err;
  logic [RW-1:0]               error_row;
  logic [CW-1:0]               error_col;
  logic [DEPTH-1:0][WIDTH-1:0] data_fix_p1;
  logic                        det_p1;

  logic                        vld_p2;

  // Stage 0: syndromes straight from the received matrix
  always_comb begin
    row_syn_p0 = '0;
    col_syn_p0 = '0;
    for (int r = 0; r < DEPTH; r++) row_syn_p0[r] = (^data_in[r]) ^ row_parity[r];
    for (int c = 0; c < WIDTH; c++) begin
      col_syn_p0[c] = col_parity[c];
      for (int r = 0; r < DEPTH; r++) col_syn_p0[c] = col_syn_p0[c] ^ data_in[r][c];
    end
  end

  // Stage 1 register: data and syndromes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1    <= '0;
      row_syn_p1 <= '0;
      col_syn_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      data_p1    <= data_in;
      row_syn_p1 <= row_syn_p0;
      col_syn_p1 <= col_syn_p0;
      vld_p1     <= 1'b1;
    end
  end

  // Locate a single data error: exactly one row and one column syndrome set
  always_comb begin
    row_cnt     = ones_row(row_syn_p1);
    col_cnt     = ones_col(col_syn_p1);
    single_err  = (row_cnt == 1) && (col_cnt == 1);
    det_p1      = (row_syn_p1 != '0) || (col_syn_p1 != '0);
    error_row   = '0;
    error_col   = '0;
    if (single_err) begin
      for (int r = 0; r < DEPTH; r++) if (row_syn_p1[r]) error_row = RW'(r);
      for (int c = 0; c < WIDTH; c++) if (col_syn_p1[c]) error_col = CW'(c);
    end
    data_fix_p1 = data_p1;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (single_err && (error_row == RW'(r)) && (error_col == CW'(c)))
          data_fix_p1[r][c] = ~data_p1[r][c];
      end
    end
  end

  // Stage 2 register: corrected data and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_corrected  <= '0;
      error_detected  <= 1'b0;
      error_corrected <= 1'b0;
      vld_p2          <= 1'b0;
    end else begin
      data_corrected  <= data_fix_p1;
      error_detected  <= det_p1;
      error_corrected <= single_err;
      vld_p2          <= vld_p1;
    end
  end

  assign complete = vld_p2;

`ifdef FEC_ERR_COUNT_EN
  // Counts alongside the stage-2 result so it matches error_corrected on the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err_count <= '0;
    else if (single_err) err_count <= sat_inc(err_count);
  end
`endif

endmodule

// File: tb/tb_fec.sv
// Self-checking bench for fec (4x4): vector table, hand-written corner sequences,
// and randomized streaming against a counting-based reference model.
module tb_fec;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0][3:0]  data_in = '0;
  logic [3:0]       row_parity = '0;
  logic [3:0]       col_parity = '0;
  logic [3:0][3:0]  data_corrected;
  logic             error_detected;
  logic             error_corrected;
  logic             complete;
`ifdef FEC_ERR_COUNT_EN
  logic [15:0]      err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  fec #(.WIDTH(4), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .row_parity      (row_parity),
    .col_parity      (col_parity),
    .data_corrected  (data_corrected),
    .error_detected  (error_detected),
    .error_corrected (error_corrected),
`ifdef FEC_ERR_COUNT_EN
    .err_count       (err_count),
`endif
    .complete        (complete)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rp;
    logic [3:0]  cp;
    logic [15:0] exp_data;
    logic        exp_det;
    logic        exp_corr;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        det;
    logic        corr;
  } exp_t;

  vec_t tbl[10];
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count ones per row/column, parity mismatch = odd total
  function automatic void model(input logic [15:0] d, input logic [3:0] rp, input logic [3:0] cp,
                                output logic [15:0] od, output logic det, output logic corr);
    int nr, nc, er, ec, ones;
    nr = 0; nc = 0; er = 0; ec = 0;
    for (int r = 0; r < 4; r++) begin
      ones = int'(rp[r]);
      for (int c = 0; c < 4; c++) ones += int'(d[r*4+c]);
      if (ones % 2 == 1) begin nr++; er = r; end
    end
    for (int c = 0; c < 4; c++) begin
      ones = int'(cp[c]);
      for (int r = 0; r < 4; r++) ones += int'(d[r*4+c]);
      if (ones % 2 == 1) begin nc++; ec = c; end
    end
    od   = d;
    det  = (nr + nc) > 0;
    corr = (nr == 1) && (nc == 1);
    if (corr) od[er*4+ec] = ~od[er*4+ec];
  endfunction

  function automatic void gen_par(input logic [15:0] d, output logic [3:0] rp, output logic [3:0] cp);
    int ones;
    for (int r = 0; r < 4; r++) begin
      ones = 0;
      for (int c = 0; c < 4; c++) ones += int'(d[r*4+c]);
      rp[r] = (ones % 2 == 1);
    end
    for (int c = 0; c < 4; c++) begin
      ones = 0;
      for (int r = 0; r < 4; r++) ones += int'(d[r*4+c]);
      cp[c] = (ones % 2 == 1);
    end
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".data"}, 32'(data_corrected), 32'(e.d));
    check({tag, ".det"},  32'(error_detected), 32'(e.det));
    check({tag, ".corr"}, 32'(error_corrected), 32'(e.corr));
    check({tag, ".complete"}, 32'(complete), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".data"}, 32'(data_corrected), 32'd0);
    check({tag, ".det"},  32'(error_detected), 32'd0);
    check({tag, ".corr"}, 32'(error_corrected), 32'd0);
    check({tag, ".complete"}, 32'(complete), 32'd0);
`ifdef FEC_ERR_COUNT_EN
    check({tag, ".err_count"}, 32'(err_count), 32'd0);
`endif
  endtask

  task automatic stream(input int n);
    logic [15:0] d, od;
    logic [3:0]  rp, cp;
    logic        det, corr;
    exp_t        e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        e = q.pop_front();
        if (e.corr) exp_count++;
        check_out("stream", e);
`ifdef FEC_ERR_COUNT_EN
        check("stream.err_count", 32'(err_count), 32'(exp_count));
`endif
      end
      d = 16'($urandom);
      gen_par(d, rp, cp);
      case ($urandom_range(0, 4))
        1: d  = d ^ (16'h1 << $urandom_range(0, 15));
        2: rp = rp ^ (4'h1 << $urandom_range(0, 3));
        3: cp = cp ^ (4'h1 << $urandom_range(0, 3));
        4: begin d = d ^ 16'($urandom); rp = 4'($urandom); end
        default: ;
      endcase
      data_in = d; row_parity = rp; col_parity = cp;
      model(d, rp, cp, od, det, corr);
      e.d = od; e.det = det; e.corr = corr;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      if (e.corr) exp_count++;
      check_out("drain", e);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_zero("rst_async");
    q.delete();
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release.complete_1clk", 32'(complete), 32'd0);
    @(negedge clk);
    check("rst_release.complete_2clk", 32'(complete), 32'd1);
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{16'h0000, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{16'h0200, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b1};
    tbl[2] = '{16'h7FFE, 4'b0000, 4'b0000, 16'h7FFE, 1'b1, 1'b0};
    tbl[3] = '{16'h0000, 4'b0010, 4'b0000, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 4'b0000, 4'b1000, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 4'b1101, 4'b0100, 16'h1234, 1'b0, 1'b0};
    tbl[6] = '{16'h1224, 4'b1101, 4'b0100, 16'h1234, 1'b1, 1'b1};
    tbl[7] = '{16'hFFFF, 4'b0000, 4'b0000, 16'hFFFF, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b1};
    tbl[9] = '{16'h0001, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b1};

    // Reset held: everything zero
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset.complete_1clk", 32'(complete), 32'd0);
    @(negedge clk);
    e.d = 16'h0; e.det = 1'b0; e.corr = 1'b0;
    check_out("all_zero", e);

    // Table: hold each vector, result is visible two edges later
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      data_in = tbl[i].data; row_parity = tbl[i].rp; col_parity = tbl[i].cp;
      repeat (2) @(negedge clk);
      e.d = tbl[i].exp_data; e.det = tbl[i].exp_det; e.corr = tbl[i].exp_corr;
      check_out($sformatf("vec%0d", i), e);
    end

    // Located indices for a single error at [2][1], and zero for an uncorrectable pattern
    @(negedge clk);
    data_in = 16'h0200; row_parity = '0; col_parity = '0;
    @(posedge clk); #1;
    check("error_row", 32'(dut.error_row), 32'd2);
    check("error_col", 32'(dut.error_col), 32'd1);
    @(negedge clk);
    data_in = 16'h7FFE;
    @(posedge clk); #1;
    check("error_row_uncorr", 32'(dut.error_row), 32'd0);
    check("error_col_uncorr", 32'(dut.error_col), 32'd0);

    // Back-to-back random matrices, reset mid-stream, then continue
    pulse_reset();
    stream(150);
    pulse_reset();
    stream(150);
    drain();

`ifdef FEC_ERR_COUNT_EN
    // Three corrected matrices in a row then clean traffic
    pulse_reset();
    @(negedge clk);
    data_in = 16'h0200; row_parity = '0; col_parity = '0;
    repeat (3) @(negedge clk);
    data_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("err_count_three", 32'(err_count), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
